// File: rtl/cap_meas_sequencer_if.sv
// Host/comparator-side bundle for the capacitor-charge measurement sequencer.
// The slave modport is the sequencer. The master modport is the host/analog front end.
interface cap_meas_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             START;
    logic             ABORT;
    logic             COMP;
    logic             READY;
    logic             RESET;
    logic             CLK_EN;
    logic             BUSY;
    logic             VALID;
    logic [CNT_W-1:0] RESULT;
    logic [1:0]       ERR;

    modport slave (
        input  START, ABORT, COMP, READY,
        output RESET, CLK_EN, BUSY, VALID, RESULT, ERR
    );

    modport master (
        output START, ABORT, COMP, READY,
        input  RESET, CLK_EN, BUSY, VALID, RESULT, ERR
    );
endinterface

// File: rtl/cap_meas_sequencer.sv
// Discharge/settle/measure sequencer: times the synchronized comparator edge per sample,
// averages 2^NAVG_LOG2 samples and returns the result (or a fault code) over valid/ready.
module cap_meas_sequencer #(
    parameter int CNT_W          = 16,
    parameter int RESET_CYCLES   = 32,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 60000,
    parameter int NAVG_LOG2      = 2
) (
    input logic                  clock,
    input logic                  RST_N,
    cap_meas_sequencer_if.slave  bus
);
    localparam int PH_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX) + 1;
    localparam int IDX_W  = (NAVG_LOG2 > 0) ? NAVG_LOG2 : 1;
    localparam int ACC_W  = CNT_W + NAVG_LOG2;

    localparam logic [PH_W-1:0]  PH_DISCH_LAST  = PH_W'(RESET_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'((1 << NAVG_LOG2) - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DISCH  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] MEAS   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]       state_q,  state_d;
    logic [PH_W-1:0]  ph_q,     ph_d;
    logic [CNT_W-1:0] meas_q,   meas_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [ACC_W-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic [1:0]       err_q,    err_d;
    logic             comp_m_q, comp_s_q;
    logic [ACC_W-1:0] acc_sum;

    assign acc_sum = acc_q + ACC_W'(meas_q);

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        meas_d   = meas_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        err_d    = err_q;
        // ABORT outranks every other transition and leaves ERR/RESULT untouched
        if (state_q != IDLE && bus.ABORT) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.START) begin
                    state_d = DISCH;
                    ph_d    = '0;
                    acc_d   = '0;
                    idx_d   = '0;
                    err_d   = 2'b00;
                end
                DISCH: if (ph_q == PH_DISCH_LAST) begin
                    state_d = SETTLE;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
                SETTLE: if (ph_q == PH_SETTLE_LAST) begin
                    if (comp_s_q) begin
                        state_d  = DONE;
                        err_d    = 2'b10;
                        result_d = '1;
                    end else begin
                        state_d = MEAS;
                        meas_d  = '0;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
                MEAS: if (comp_s_q) begin
                    // Comparator edge wins over a timeout landing in the same cycle
                    acc_d = acc_sum;
                    if (idx_q == IDX_LAST) begin
                        state_d  = DONE;
                        err_d    = 2'b00;
                        result_d = CNT_W'(acc_sum >> NAVG_LOG2);
                    end else begin
                        state_d = DISCH;
                        idx_d   = idx_q + 1'b1;
                        ph_d    = '0;
                    end
                end else if (meas_q == MEAS_LAST) begin
                    state_d  = DONE;
                    err_d    = 2'b01;
                    result_d = '1;
                end else begin
                    meas_d = meas_q + 1'b1;
                end
                DONE: if (bus.READY) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            ph_q     <= '0;
            meas_q   <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            err_q    <= 2'b00;
            comp_m_q <= 1'b0;
            comp_s_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            meas_q   <= meas_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            err_q    <= err_d;
            comp_m_q <= bus.COMP;
            comp_s_q <= comp_m_q;
        end
    end

    assign bus.RESET  = (state_q == DISCH);
    assign bus.CLK_EN = (state_q == MEAS);
    assign bus.BUSY   = (state_q != IDLE);
    assign bus.VALID  = (state_q == DONE);
    assign bus.RESULT = result_q;
    assign bus.ERR    = err_q;
endmodule

// File: tb/tb_cap_meas_sequencer.sv
// Directed bench for cap_meas_sequencer: burst averaging, timeout, stuck comparator,
// backpressure, abort, comp/timeout race and asynchronous reset.
module tb_cap_meas_sequencer;
    localparam int CNT_W = 8;

    logic clock;
    logic RST_N;
    int   n_cmp;
    int   n_bad;

    int   rst_cyc, en_cyc, both_cyc, valid_cyc, disch_n;
    logic rst_prev;

    cap_meas_sequencer_if #(.CNT_W(CNT_W)) bus ();

    cap_meas_sequencer #(
        .CNT_W(CNT_W), .RESET_CYCLES(4), .SETTLE_CYCLES(3),
        .TIMEOUT_CYCLES(100), .NAVG_LOG2(2)
    ) dut (
        .clock(clock),
        .RST_N(RST_N),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Running activity counters; tests snapshot and difference them
    initial begin
        rst_cyc = 0; en_cyc = 0; both_cyc = 0; valid_cyc = 0; disch_n = 0; rst_prev = 1'b0;
    end
    always @(negedge clock) begin
        if (RST_N) begin
            if (bus.RESET) rst_cyc++;
            if (bus.CLK_EN) en_cyc++;
            if (bus.RESET && bus.CLK_EN) both_cyc++;
            if (bus.VALID) valid_cyc++;
            if (bus.RESET && !rst_prev) disch_n++;
        end
        rst_prev = bus.RESET;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.CLK_EN;
            1:       return bus.RESET;
            default: return bus.VALID;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        int n;
        n = 0;
        while (!sig(which) && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(n < 500), 32'd1);
    endtask

    task automatic pulse_start();
        bus.START = 1'b1;
        @(negedge clock);
        bus.START = 1'b0;
    endtask

    // Raise COMP so comp_s is first high at meas_cnt == target
    task automatic run_sample(input int target);
        wait_for(0, "wait_clk_en");
        repeat (target - 2) @(negedge clock);
        bus.COMP = 1'b1;
    endtask

    task automatic handshake();
        bus.READY = 1'b1;
        @(negedge clock);
        bus.READY = 1'b0;
        chk("hs_valid_low", 32'(bus.VALID), 32'd0);
        chk("hs_busy_low",  32'(bus.BUSY),  32'd0);
    endtask

    int b_rst, b_en, b_dn, b_val;

    initial begin
        n_cmp = 0; n_bad = 0;
        bus.START = 1'b0; bus.ABORT = 1'b0; bus.COMP = 1'b0; bus.READY = 1'b0;
        RST_N = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_reset",  32'(bus.RESET),  32'd0);
        chk("rst_clk_en", 32'(bus.CLK_EN), 32'd0);
        chk("rst_busy",   32'(bus.BUSY),   32'd0);
        chk("rst_valid",  32'(bus.VALID),  32'd0);
        chk("rst_result", 32'(bus.RESULT), 32'd0);
        chk("rst_err",    32'(bus.ERR),    32'd0);
        RST_N = 1'b1;
        @(negedge clock);

        // Normal burst: edges at 10..13 -> (10+11+12+13)>>2 = 11
        b_rst = rst_cyc; b_en = en_cyc; b_dn = disch_n;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            run_sample(10 + i);
            wait_for((i < 3) ? 1 : 2, "wait_next");
            bus.COMP = 1'b0;
        end
        chk("norm_valid",  32'(bus.VALID),  32'd1);
        chk("norm_result", 32'(bus.RESULT), 32'd11);
        chk("norm_err",    32'(bus.ERR),    32'd0);
        chk("norm_rst_cyc", 32'(rst_cyc - b_rst), 32'd16);
        chk("norm_disch_n", 32'(disch_n - b_dn),  32'd4);
        chk("norm_en_cyc",  32'(en_cyc - b_en),   32'd50);
        handshake();
        chk("norm_result_keep", 32'(bus.RESULT), 32'd11);

        // Timeout with backpressure and an ignored START
        b_rst = rst_cyc; b_en = en_cyc; b_dn = disch_n;
        pulse_start();
        wait_for(2, "wait_to_valid");
        chk("to_en_cyc",  32'(en_cyc - b_en),   32'd100);
        chk("to_rst_cyc", 32'(rst_cyc - b_rst), 32'd4);
        chk("to_disch_n", 32'(disch_n - b_dn),  32'd1);
        for (int c = 0; c < 20; c++) begin
            bus.START = (c == 5);
            chk("bp_valid",  32'(bus.VALID),  32'd1);
            chk("bp_result", 32'(bus.RESULT), 32'hFF);
            chk("bp_err",    32'(bus.ERR),    32'd1);
            @(negedge clock);
        end
        bus.START = 1'b0;
        handshake();
        repeat (5) @(negedge clock);
        chk("bp_no_queue", 32'(bus.BUSY), 32'd0);

        // Stuck comparator
        b_rst = rst_cyc; b_en = en_cyc;
        bus.COMP = 1'b1;
        pulse_start();
        wait_for(2, "wait_stuck_valid");
        chk("stuck_err",     32'(bus.ERR),    32'd2);
        chk("stuck_result",  32'(bus.RESULT), 32'hFF);
        chk("stuck_en_cyc",  32'(en_cyc - b_en),   32'd0);
        chk("stuck_rst_cyc", 32'(rst_cyc - b_rst), 32'd4);
        handshake();
        bus.COMP = 1'b0;
        repeat (3) @(negedge clock);

        // Abort in MEAS of sample 2
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            run_sample(10);
            wait_for(1, "wait_abort_disch");
            bus.COMP = 1'b0;
        end
        wait_for(0, "wait_abort_meas");
        repeat (5) @(negedge clock);
        b_val = valid_cyc;
        bus.ABORT = 1'b1;
        @(negedge clock);
        bus.ABORT = 1'b0;
        chk("abort_busy",   32'(bus.BUSY),   32'd0);
        chk("abort_clk_en", 32'(bus.CLK_EN), 32'd0);
        repeat (10) @(negedge clock);
        chk("abort_no_valid", 32'(valid_cyc - b_val), 32'd0);
        chk("abort_err",      32'(bus.ERR),           32'd0);

        // Comparator edge on the last MEAS cycle counts as a valid sample
        b_dn = disch_n;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            run_sample(99);
            wait_for((i < 3) ? 1 : 2, "wait_race_next");
            bus.COMP = 1'b0;
        end
        chk("race_err",     32'(bus.ERR),    32'd0);
        chk("race_result",  32'(bus.RESULT), 32'd99);
        chk("race_disch_n", 32'(disch_n - b_dn), 32'd4);
        handshake();

        // Asynchronous reset mid-DISCH
        pulse_start();
        wait_for(1, "wait_rst_disch");
        #2 RST_N = 1'b0;
        #1;
        chk("arst_reset",  32'(bus.RESET),  32'd0);
        chk("arst_clk_en", 32'(bus.CLK_EN), 32'd0);
        chk("arst_busy",   32'(bus.BUSY),   32'd0);
        chk("arst_valid",  32'(bus.VALID),  32'd0);
        @(negedge clock);
        RST_N = 1'b1;
        repeat (2) @(negedge clock);
        chk("arst_idle",   32'(bus.BUSY),   32'd0);
        chk("arst_result", 32'(bus.RESULT), 32'd0);

        chk("never_both", 32'(both_cyc), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cap_meas_sequencer.md
Name: cap_meas_sequencer

Overview:
Sequences the capacitor-charge time measurement. Per sample it discharges the capacitor, lets it settle, enables the charge counter, and times the synchronized comparator edge. It averages 2^NAVG_LOG2 samples into one result, flags timeout and stuck-comparator faults, and returns the result to the host over a valid/ready handshake.

Parameters:
CNT_W, 16, width of the per-sample cycle counter and of RESULT
RESET_CYCLES, 32, cycles RESET is held high per sample (min 1)
SETTLE_CYCLES, 4, cycles after RESET drops before counting starts (min 3, covers synchronizer)
TIMEOUT_CYCLES, 60000, maximum MEAS cycles per sample (≤ 2^CNT_W - 1)
NAVG_LOG2, 2, log2 of the number of samples averaged (0 means a single sample)

Ports:
clock  in  1  system clock
RST_N  in  1  asynchronous reset, active low
START  in  1  request a measurement burst; sampled only in IDLE
ABORT  in  1  cancel the current burst; sampled in any state except IDLE
COMP  in  1  comparator output, asynchronous; high when capacitor ≥ VREF
READY  in  1  host accepts RESULT
RESET  out  1  capacitor discharge, active high
CLK_EN  out  1  charge-counter enable, high in MEAS
BUSY  out  1  high in any state other than IDLE
VALID  out  1  RESULT/ERR valid, held until accepted
RESULT  out  CNT_W  averaged count; all-ones on any fault
ERR  out  2  bit0 timeout, bit1 comparator stuck high; 0 on success

Behaviour:
- Reset (RST_N=0, async): state=IDLE, all counters, accumulator and synchronizer flops = 0; RESET=CLK_EN=BUSY=VALID=0, RESULT=0, ERR=0.
- COMP passes through a 2-flop synchronizer (comp_s), 2-cycle latency. Only comp_s is used internally.
- RESET, CLK_EN and BUSY are pure decodes of the registered state. RESET=1 only in DISCH; CLK_EN=1 only in MEAS; no cycle has both high.
- States:
  - IDLE: START=1 → DISCH; clear accumulator, sample_idx=0, ERR=0.
  - DISCH: hold exactly RESET_CYCLES cycles → SETTLE.
  - SETTLE: hold exactly SETTLE_CYCLES cycles. On the last cycle, comp_s=1 → DONE with ERR=2'b10. Otherwise → MEAS.
  - MEAS: meas_cnt=0 on the first cycle and increments each cycle.
    - comp_s=1 → acc += meas_cnt (value in that cycle). If sample_idx = 2^NAVG_LOG2-1 → DONE, else sample_idx+1 and → DISCH.
    - comp_s=0 and meas_cnt = TIMEOUT_CYCLES-1 → DONE with ERR=2'b01.
    - comp_s=1 and timeout in the same cycle: comp wins, sample is valid.
  - DONE: VALID=1. RESULT = acc >> NAVG_LOG2 (truncating) when ERR=0, else all-ones. RESULT and ERR are registered on DONE entry and stay stable while VALID=1. VALID&READY → IDLE next cycle, VALID=0 that cycle, RESULT/ERR retain value.
- Accumulator width is CNT_W+NAVG_LOG2 bits; it cannot overflow.
- START outside IDLE is ignored; no queuing.
- ABORT=1 in any state except IDLE → IDLE next cycle. No VALID is produced, ERR is unchanged, RESET/CLK_EN drop. ABORT in DONE discards the pending result. ABORT has priority over every other transition.
- RST_N low mid-operation forces reset values immediately, including RESET=0 and CLK_EN=0.
- READY is ignored when VALID=0.

Test Plan:
Test parameters: CNT_W=8, RESET_CYCLES=4, SETTLE_CYCLES=3, TIMEOUT_CYCLES=100, NAVG_LOG2=2.

1. Reset: RST_N low mid-DISCH → RESET, CLK_EN, BUSY and VALID drop asynchronously. After release, state is IDLE and RESULT=0.
2. Normal burst: START; drive COMP so comp_s rises at meas_cnt 10, 11, 12, 13 on samples 0–3, dropping COMP during each DISCH → RESET high exactly 4 cycles per sample, VALID with RESULT=11 (46>>2), ERR=0.
3. Timeout: START with COMP held low → CLK_EN high exactly 100 cycles, then VALID, ERR=01, RESULT=8'hFF; no further DISCH.
4. Stuck comparator: COMP held high from START → one DISCH+SETTLE, CLK_EN never asserted, VALID with ERR=10, RESULT=8'hFF.
5. Backpressure: READY low 20 cycles in DONE, START pulsed meanwhile → VALID, RESULT and ERR stable, START ignored. READY high → IDLE next cycle, BUSY=0.
6. Abort and race: ABORT in MEAS of sample 2 → IDLE next cycle, no VALID. Separately, comp_s rises on meas_cnt=99 → counted as valid, ERR=0 on completion.
